// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit combinational full adder used as the serial adder's datapath cell.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per cycle, LSB first, through a single full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               carry;
    logic [CNT_W-1:0]   bit_cnt;
    logic               fa_s;
    logic               fa_co;

    serial_fa_bit u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // FSM, operand shifters, carry flop and counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        op_a    <= a;
                        op_b    <= b;
                        carry   <= cin;
                        bit_cnt <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_co;
                    // Counter stops at the last bit so it never wraps.
                    if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_co;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=32.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start32, cin32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    int checks   = 0;
    int errors   = 0;
    int done8_n  = 0;
    int done32_n = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done8)  done8_n++;
        if (done32) done32_n++;
        if ((busy8 && done8) || (busy32 && done32)) overlap++;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        int n;
        int bc;
        a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n  = 0;
        bc = busy8 ? 1 : 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
            if (busy8) bc++;
        end
        check({tag, " latency"}, 64'(n), 64'd8);
        check({tag, " busy_cycles"}, 64'(bc), 64'd8);
        check({tag, " sum"}, 64'(sum8), 64'(exp_sum));
        check({tag, " cout"}, 64'(cout8), 64'(exp_cout));
        tick();
        check({tag, " done_pulse_len"}, 64'(done8), 64'd0);
        check({tag, " sum_hold"}, 64'(sum8), 64'(exp_sum));
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic [31:0] exp_sum, input logic exp_cout, input string tag);
        int n;
        a32 = x; b32 = y; cin32 = ci; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        n = 0;
        while (!done32 && n < 80) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " sum"}, 64'(sum32), 64'(exp_sum));
        check({tag, " cout"}, 64'(cout32), 64'(exp_cout));
    endtask

    initial begin
        int          d0;
        int          n;
        logic [7:0]  ra8, rb8;
        logic [8:0]  ref8;
        logic [31:0] ra32, rb32;
        logic [32:0] ref32;
        logic        rc;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        tick();
        tick();
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset sum", 64'(sum8), 64'd0);
        check("reset cout", 64'(cout8), 64'd0);
        check("reset busy32", 64'(busy32), 64'd0);
        rst_n = 1'b1;
        tick();

        // Abort mid-operation: 0x55 + 0x0F, three bits processed give partial sum 0x80.
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("midop busy", 64'(busy8), 64'd1);
        tick(); tick(); tick();
        check("midop partial_sum", 64'(sum8), 64'h80);
        check("midop cout_run", 64'(cout8), 64'd0);
        d0 = done8_n;
        rst_n = 1'b0;
        tick();
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        check("abort sum", 64'(sum8), 64'd0);
        check("abort cout", 64'(cout8), 64'd0);
        rst_n = 1'b1;
        repeat (12) tick();
        check("abort no_done", 64'(done8_n - d0), 64'd0);
        op8(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, "after_reset");

        op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "basic");
        op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ripple_ff_00_c1");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple_ff_ff_c1");

        // A start pulse during RUN must be ignored.
        d0 = done8_n;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin tick(); n++; end
        check("ignore sum", 64'(sum8), 64'h30);
        check("ignore cout", 64'(cout8), 64'd0);
        repeat (15) tick();
        check("ignore single_done", 64'(done8_n - d0), 64'd1);
        check("ignore idle", 64'(busy8), 64'd0);

        // Back-to-back with start held high.
        d0 = done8_n;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h7F; b8 = 8'h01;
        n = 0;
        while (!done8 && n < 40) begin tick(); n++; end
        check("b2b first_latency", 64'(n), 64'd8);
        check("b2b first_sum", 64'(sum8), 64'h00);
        check("b2b first_cout", 64'(cout8), 64'd1);
        tick();
        n = 1;
        while (!done8 && n < 40) begin tick(); n++; end
        start8 = 1'b0;
        check("b2b gap", 64'(n), 64'd9);
        check("b2b second_sum", 64'(sum8), 64'h80);
        check("b2b second_cout", 64'(cout8), 64'd0);
        tick();
        check("b2b done_count", 64'(done8_n - d0), 64'd2);

        op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, "w32_ripple");
        op32(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, "w32_basic");

        for (int i = 0; i < 1000; i++) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            rc   = 1'($urandom_range(0, 1));
            ref8 = {1'b0, ra8} + {1'b0, rb8} + 9'(rc);
            op8(ra8, rb8, rc, ref8[7:0], ref8[8], "rand8");
        end
        for (int i = 0; i < 1000; i++) begin
            ra32  = 32'($urandom);
            rb32  = 32'($urandom);
            rc    = 1'($urandom_range(0, 1));
            ref32 = {1'b0, ra32} + {1'b0, rb32} + 33'(rc);
            op32(ra32, rb32, rc, ref32[31:0], ref32[32], "rand32");
        end

        check("busy_done_overlap", 64'(overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
